// File: rtl/fmap_streamer_pkg.sv
// Shared types and constants for the feature-map streamer.
package fmap_streamer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_WGT  = 2'd2,
    ST_DATA = 2'd3
  } fms_state_e;

  localparam int N_L0   = 144;
  localparam int N_L1   = 25;
  localparam int N_WGT  = 9;
  localparam int BYTE_W = 8;
  localparam int ELEM_W = 15;

  // Upper stream byte of an element: zero-padded top seven bits.
  function automatic logic [BYTE_W-1:0] hi_byte(input logic [ELEM_W-1:0] e);
    return {1'b0, e[ELEM_W-1:BYTE_W]};
  endfunction

endpackage

// File: rtl/fmap_streamer_fms_buf.sv
// Feature buffer: one write port, one read port with a registered read.
// The read register holds its value while rd_en is low, so the streamer
// can prefetch the next element and consume it over two output bytes.
module fms_buf #(
  parameter int DEPTH = 144,
  parameter int AW    = 8,
  parameter int DW    = 15
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // Storage write.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Registered read, held between enables.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fmap_streamer.sv
// Feature-map streamer: captures one pooled map into fms_buf, then emits
// a byte frame of 9 weights followed by each element as hi/lo bytes.
// Optional build macro FMS_OVF_CNT_EN adds o_ovf_cnt, a saturating count of
// in_valid beats dropped outside FILL.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; weight writes accepted here only
// FILL    | writing in_valid beats into the buffer until N stored
// WGT     | o_data carries weight byte wcnt (0..8)
// DATA    | o_data carries hi (lo_q=0) or lo (lo_q=1) byte of element ecnt
module fmap_streamer
  import fmap_streamer_pkg::*;
#(
  parameter int FM_DEPTH = 144
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        layer_num,
  input  logic              start,
  input  logic              w_we,
  input  logic [3:0]        w_addr,
  input  logic [BYTE_W-1:0] w_data,
  input  logic              in_valid,
  input  logic [ELEM_W-1:0] in_data,
  input  logic              o_ready,
  output logic              o_valid,
  output logic [BYTE_W-1:0] o_data,
  output logic              o_last,
  output logic              busy,
  output logic              err
`ifdef FMS_OVF_CNT_EN
  ,
  output logic [7:0]        o_ovf_cnt
`endif
);

  localparam int AW = $clog2(FM_DEPTH);

  fms_state_e        state_q, state_d;
  logic [AW-1:0]     n_q, n_d;
  logic [AW-1:0]     fill_q, fill_d;
  logic [AW-1:0]     ecnt_q, ecnt_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic              lo_q, lo_d;
  logic              err_d;
  logic              o_valid_d, o_last_d;
  logic [BYTE_W-1:0] o_data_d;
  logic [BYTE_W-1:0] wgt_q [N_WGT];
  logic              buf_we, rd_en;
  logic [AW-1:0]     rd_addr;
  logic [ELEM_W-1:0] rd_data;
  logic              advance;

  assign advance = o_valid && o_ready;
  assign busy    = (state_q != ST_IDLE);

  fms_buf #(
    .DEPTH (FM_DEPTH),
    .AW    (AW),
    .DW    (ELEM_W)
  ) u_buf (
    .clk     (clk),
    .we      (buf_we),
    .wr_addr (fill_q),
    .wr_data (in_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Weight register file; writes outside IDLE or to index > 8 are ignored.
  always_ff @(posedge clk) begin
    if (w_we && (state_q == ST_IDLE) && (w_addr < 4'(N_WGT)))
      wgt_q[w_addr] <= w_data;
  end

  // State, counters and registered stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      fill_q  <= '0;
      ecnt_q  <= '0;
      wcnt_q  <= '0;
      lo_q    <= 1'b0;
      err     <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      fill_q  <= fill_d;
      ecnt_q  <= ecnt_d;
      wcnt_q  <= wcnt_d;
      lo_q    <= lo_d;
      err     <= err_d;
      o_valid <= o_valid_d;
      o_data  <= o_data_d;
      o_last  <= o_last_d;
    end
  end

  // Next-state, buffer control and next output byte. Element e+1 is
  // prefetched on the edge that loads the lo byte of element e, so the
  // read register is ready before the next hi byte is needed.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    fill_d    = fill_q;
    ecnt_d    = ecnt_q;
    wcnt_d    = wcnt_q;
    lo_d      = lo_q;
    err_d     = err;
    o_valid_d = o_valid;
    o_data_d  = o_data;
    o_last_d  = o_last;
    buf_we    = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (!layer_num[1]) begin
            state_d = ST_FILL;
            n_d     = layer_num[0] ? AW'(N_L1) : AW'(N_L0);
            fill_d  = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_FILL: begin
        if (in_valid) begin
          buf_we = 1'b1;
          fill_d = fill_q + AW'(1);
          if ((fill_q + AW'(1)) == n_q) begin
            state_d   = ST_WGT;
            wcnt_d    = '0;
            o_valid_d = 1'b1;
            o_data_d  = wgt_q[0];
            o_last_d  = 1'b0;
            rd_en     = 1'b1;
            rd_addr   = '0;
          end
        end
      end
      ST_WGT: begin
        if (advance) begin
          if (wcnt_q == 4'(N_WGT - 1)) begin
            state_d  = ST_DATA;
            ecnt_d   = '0;
            lo_d     = 1'b0;
            o_data_d = hi_byte(rd_data);
          end else begin
            wcnt_d   = wcnt_q + 4'd1;
            o_data_d = wgt_q[wcnt_q + 4'd1];
          end
        end
      end
      ST_DATA: begin
        if (advance) begin
          if (o_last) begin
            state_d   = ST_IDLE;
            o_valid_d = 1'b0;
            o_last_d  = 1'b0;
          end else if (!lo_q) begin
            lo_d     = 1'b1;
            o_data_d = rd_data[BYTE_W-1:0];
            o_last_d = (ecnt_q == (n_q - AW'(1)));
            if (ecnt_q != (n_q - AW'(1))) begin
              rd_en   = 1'b1;
              rd_addr = ecnt_q + AW'(1);
            end
          end else begin
            lo_d     = 1'b0;
            ecnt_d   = ecnt_q + AW'(1);
            o_data_d = hi_byte(rd_data);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef FMS_OVF_CNT_EN
  logic drop;
  assign drop = in_valid && (state_q != ST_FILL);

  // Saturating count of in_valid beats that were not captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) o_ovf_cnt <= '0;
    else if (drop && (o_ovf_cnt != 8'hFF)) o_ovf_cnt <= o_ovf_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_fmap_streamer.sv
// Directed bench for fmap_streamer. Expected frames come from a small
// byte model built from the weights/elements the bench drives; a few
// hand-computed constants pin key byte positions.
module tb_fmap_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  layer_num;
  logic        start;
  logic        w_we;
  logic [3:0]  w_addr;
  logic [7:0]  w_data;
  logic        in_valid;
  logic [14:0] in_data;
  logic        o_ready;
  logic        o_valid;
  logic [7:0]  o_data;
  logic        o_last;
  logic        busy;
  logic        err;
`ifdef FMS_OVF_CNT_EN
  logic [7:0]  o_ovf_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]  wgt_m  [9];
  logic [14:0] elem_m [144];
  logic [7:0]  got    [300];

  fmap_streamer #(.FM_DEPTH(144)) dut (
    .clk       (clk),
    .rst       (rst),
    .layer_num (layer_num),
    .start     (start),
    .w_we      (w_we),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .o_ready   (o_ready),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_last    (o_last),
    .busy      (busy),
    .err       (err)
`ifdef FMS_OVF_CNT_EN
    ,
    .o_ovf_cnt (o_ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int k);
    int e;
    if (k < 9) return wgt_m[k];
    e = (k - 9) / 2;
    if (((k - 9) % 2) == 0) return {1'b0, elem_m[e][14:8]};
    return elem_m[e][7:0];
  endfunction

  task automatic write_weights();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      w_we = 1'b1; w_addr = 4'(i); w_data = wgt_m[i];
    end
    @(negedge clk);
    w_we = 1'b0;
  endtask

  // mode 0: o_ready high; mode 1: o_ready toggles each cycle.
  // abort_at > 0 returns after that many bytes have been accepted.
  // disturb adds an in_valid in the start cycle, plus a start pulse and a
  // weight write during FILL; all of them must be ignored.
  task automatic run_frame(input int layer, input int mode, input int abort_at, input bit disturb);
    int n, total, idx, cyc;
    bit prev_hold;
    logic [7:0] pd;
    logic pl;
    n = (layer == 1) ? 25 : 144;
    total = 9 + 2 * n;
    @(negedge clk);
    start = 1'b1; layer_num = 2'(layer); o_ready = 1'b1;
    if (disturb) begin in_valid = 1'b1; in_data = 15'h1234; end
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) chk("pre_valid", o_valid, 0);
      in_valid = 1'b1; in_data = elem_m[i];
      if (disturb && i == 5) begin
        start = 1'b1; layer_num = 2'd0;
        w_we = 1'b1; w_addr = 4'd0; w_data = 8'hEE;
      end
      @(negedge clk);
      start = 1'b0; w_we = 1'b0; in_valid = 1'b0;
    end
    chk("first_valid", o_valid, 1);
    chk("busy_frame", busy, 1);
    idx = 0; cyc = 0; prev_hold = 1'b0; pd = '0; pl = 1'b0;
    while (idx < total && cyc < 2000) begin
      o_ready = (mode == 1) ? ((cyc % 2) == 0) : 1'b1;
      if (mode == 0) chk("no_bubble", o_valid, 1);
      if (prev_hold) begin
        chk("hold_data", o_data, pd);
        chk("hold_last", o_last, pl);
      end
      prev_hold = o_valid && !o_ready;
      pd = o_data; pl = o_last;
      if (o_valid && o_ready) begin
        got[idx] = o_data;
        chk($sformatf("byte%0d", idx), o_data, exp_byte(idx));
        chk($sformatf("last%0d", idx), o_last, (idx == total - 1));
        idx++;
      end
      cyc++;
      @(negedge clk);
      if (abort_at != 0 && idx == abort_at) break;
    end
    o_ready = 1'b1;
    if (abort_at == 0) begin
      chk("frame_len", idx, total);
      chk("end_valid", o_valid, 0);
      chk("end_busy", busy, 0);
    end
  endtask

  initial begin
    rst = 1'b1; layer_num = '0; start = 1'b0; w_we = 1'b0; w_addr = '0;
    w_data = '0; in_valid = 1'b0; in_data = '0; o_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_last", o_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
`ifdef FMS_OVF_CNT_EN
    chk("rst_ovf", o_ovf_cnt, 0);
`endif
    rst = 1'b0;

    // Layer 1, weights 1..9, elements 0..24, o_ready high.
    for (int i = 0; i < 9; i++) wgt_m[i] = 8'(i + 1);
    for (int i = 0; i < 25; i++) elem_m[i] = 15'(i);
    write_weights();
    run_frame(1, 0, 0, 1'b0);
    chk("a_b0", got[0], 8'h01);
    chk("a_b8", got[8], 8'h09);
    chk("a_b9", got[9], 8'h00);
    chk("a_b10", got[10], 8'h00);
    chk("a_b12", got[12], 8'h01);
    chk("a_b57", got[57], 8'h00);
    chk("a_b58", got[58], 8'h18);

    // Layer 1, signed weights, 0x7FFF element, o_ready toggling, disturbances.
    for (int i = 0; i < 9; i++) wgt_m[i] = 8'(8'hF0 + i);
    for (int i = 0; i < 25; i++) elem_m[i] = 15'((i * 1021) & 16'h7FFF);
    elem_m[3] = 15'h7FFF;
    write_weights();
    run_frame(1, 1, 0, 1'b1);
    chk("b_7fff_hi", got[15], 8'h7F);
    chk("b_7fff_lo", got[16], 8'hFF);
    chk("b_w0", got[0], 8'hF0);

    // Reserved layer sets sticky err, no frame.
    @(negedge clk);
    start = 1'b1; layer_num = 2'd2;
    @(negedge clk);
    start = 1'b0;
    chk("err_set", err, 1);
    chk("err_busy", busy, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("err_novalid", o_valid, 0);
    end
    chk("err_sticky", err, 1);

    // Layer 0, abort by reset after 20 bytes, then a full frame.
    for (int i = 0; i < 9; i++) wgt_m[i] = 8'(8'h10 + i);
    for (int i = 0; i < 144; i++) elem_m[i] = 15'((i * 227 + 5) & 16'h7FFF);
    write_weights();
    run_frame(0, 0, 20, 1'b0);
    rst = 1'b1;
    #1;
    chk("abort_valid", o_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_valid", o_valid, 0);
    end
    write_weights();
    run_frame(0, 0, 0, 1'b0);
    chk("c_b9", got[9], 8'h00);
    chk("c_b10", got[10], 8'h05);

`ifdef FMS_OVF_CNT_EN
    chk("ovf_zero", o_ovf_cnt, 0);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 15'(i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("ovf_sat", o_ovf_cnt, 255);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
